mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller that sits in the E stage beside the ALU.
- Accepts one HI/LO operation per start pulse and sequences a fixed-latency multiply or divide.
- Drives busy, which the D-stage stall logic combines with start to hold mfhi/mflo/mult/div instructions in D.
- Holds the architectural HI/LO registers and presents them combinationally to the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  E-stage instruction is an HI/LO-writing op; single-cycle qualifier.
- op  in  4  operation code from mdu_pkg, sampled when start=1.
- rs_data  in  32  forwarded rs operand, sampled when start=1.
- rt_data  in  32  forwarded rt operand, sampled when start=1.
- busy  out  1  a multiply/divide is in flight.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset: state=IDLE, busy=0, hi=0, lo=0, counter=0, operand latches=0. Reset mid-operation aborts the operation with no HI/LO write.
- States: IDLE and RUN.
- IDLE + start + op in {MULT, MULTU, DIV, DIVU}:
  - latch op, rs_data and rt_data;
  - counter <= N-1, where N=MULT_CYCLES or DIV_CYCLES;
  - go to RUN; busy=1 from the next cycle.
- RUN:
  - counter decrements each cycle.
  - In the cycle counter==0, the result is written at that edge, state goes to IDLE and busy drops.
  - busy is high for exactly N cycles after the start cycle. The new hi/lo are visible in the first cycle with busy=0.
- IDLE + start + MTHI: hi <= rs_data at that edge. MTLO: lo <= rs_data. No busy cycle; visible the next cycle.
- start with an unknown op: ignored, no state change.
- start while busy=1: ignored. Upstream guarantees this never happens; the bench checks that it is ignored.
- MULT: {hi,lo} <= signed 32x32 -> 64-bit product. MULTU: the unsigned equivalent.
- DIV (signed):
  - lo = quotient truncated toward zero;
  - hi = remainder with the sign of the dividend;
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (rt=0): full DIV_CYCLES busy, hi/lo unchanged.
- Operands come only from the latched copies; changes on rs_data/rt_data during RUN have no effect.
- hi/lo change only at commit edges; reads during RUN return the old values. Upstream stalls mfhi/mflo in that case anyway.

Optional Feature:
- Macro MDU_MADD_EN.
- When defined, four extra op codes each start a MULT_CYCLES operation:
  - MADD: {hi,lo} += signed product;
  - MADDU: {hi,lo} += unsigned product;
  - MSUB: {hi,lo} -= signed product;
  - MSUBU: {hi,lo} -= unsigned product.
  - All arithmetic is modulo 2^64 and uses {hi,lo} at the commit edge.
- When undefined, these codes are treated as unknown ops and ignored.

Decomposition:
- Package mdu_pkg holds:
  - 4-bit op constants OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU;
  - state encodings ST_IDLE and ST_RUN.
- One combinational sub-module, mdu_arith: latched op/operands plus current hi/lo in, 64-bit result and a write-enable (which suppresses divide-by-zero) out.
- The sequencer keeps the FSM, counter and HI/LO registers.

Test Plan:
- Reset then idle: hi=0, lo=0, busy=0. Assert reset during RUN: busy=0 next cycle, hi/lo=0.
- MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 after MTHI 0x1234 -> busy 10 cycles, hi=0x1234, lo unchanged.
- MTLO rs=0xCAFEBABE -> lo=0xCAFEBABE next cycle, busy never asserted. Then MULT 0x10000 x 0x10000 -> hi=1, lo=0.
- Start DIV, change rs/rt every RUN cycle and pulse start with MULT at cycle 3 -> second start ignored, result uses the latched operands, busy stays exactly 10 cycles.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1x1 -> hi=1, lo=0. MSUB 1x1 -> hi=0, lo=0xFFFFFFFF. Without the macro, the same op codes leave hi/lo unchanged and busy=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes, FSM states and op classification for the MDU; optional MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mduState_t;

  // Ops that run for MULT_CYCLES; the accumulate family only exists with MDU_MADD_EN.
  function automatic logic isMulOp(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
    return op inside {OP_MULT, OP_MULTU};
`endif
  endfunction

  // Ops that run for DIV_CYCLES.
  function automatic logic isDivOp(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - E-stage request/HI-LO result bundle between the pipeline and the MDU
interface mdu_sequencer_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, hi, lo
  );
endinterface

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational HI/LO result for a latched MDU op; MDU_MADD_EN enables multiply-accumulate ops
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rsVal,
  input  logic [31:0] rtVal,
  input  logic [31:0] hiIn,
  input  logic [31:0] loIn,
  output logic [63:0] result,
  output logic        writeEn
);

  logic [63:0] prodS;
  logic [63:0] prodU;
  logic        divSigned;
  logic        negQuot;
  logic        negRem;
  logic [31:0] absRs;
  logic [31:0] absRt;
  logic [31:0] divisor;
  logic [31:0] quotU;
  logic [31:0] remU;
  logic [31:0] quot;
  logic [31:0] rem;

  // Products: a 64-bit multiply of sign-extended operands is the exact signed product modulo 2^64.
  always_comb begin
    prodU = {32'd0, rsVal} * {32'd0, rtVal};
    prodS = {{32{rsVal[31]}}, rsVal} * {{32{rtVal[31]}}, rtVal};
  end

  // Divide on magnitudes and fix signs afterwards, so 0x80000000 / -1 wraps to 0x80000000 rem 0 without overflow.
  always_comb begin
    divSigned = (op == OP_DIV);
    negRem    = divSigned & rsVal[31];
    negQuot   = divSigned & (rsVal[31] ^ rtVal[31]);
    absRs     = negRem ? (32'd0 - rsVal) : rsVal;
    absRt     = (divSigned & rtVal[31]) ? (32'd0 - rtVal) : rtVal;
    divisor   = (absRt == 32'd0) ? 32'd1 : absRt;
    quotU     = absRs / divisor;
    remU      = absRs % divisor;
    quot      = negQuot ? (32'd0 - quotU) : quotU;
    rem       = negRem ? (32'd0 - remU) : remU;
  end

  // Select the committed value; divide by zero leaves HI/LO untouched.
  always_comb begin
    result  = {hiIn, loIn};
    writeEn = 1'b0;
    case (op)
      OP_MULT:  begin result = prodS;      writeEn = 1'b1; end
      OP_MULTU: begin result = prodU;      writeEn = 1'b1; end
      OP_DIV,
      OP_DIVU:  begin result = {rem, quot}; writeEn = (rtVal != 32'd0); end
`ifdef MDU_MADD_EN
      OP_MADD:  begin result = {hiIn, loIn} + prodS; writeEn = 1'b1; end
      OP_MADDU: begin result = {hiIn, loIn} + prodU; writeEn = 1'b1; end
      OP_MSUB:  begin result = {hiIn, loIn} - prodS; writeEn = 1'b1; end
      OP_MSUBU: begin result = {hiIn, loIn} - prodU; writeEn = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - fixed-latency multiply/divide sequencer holding architectural HI/LO; MDU_MADD_EN adds accumulate ops
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  mdu_sequencer_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mduState_t        state;
  mduState_t        stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic [3:0]       opLat;
  logic [31:0]      rsLat;
  logic [31:0]      rtLat;
  logic [31:0]      hiReg;
  logic [31:0]      loReg;
  logic             loadOp;
  logic             commit;
  logic             writeHi;
  logic             writeLo;
  logic [63:0]      arithResult;
  logic             arithWe;

  mdu_arith uArith (
    .op      (opLat),
    .rsVal   (rsLat),
    .rtVal   (rtLat),
    .hiIn    (hiReg),
    .loIn    (loReg),
    .result  (arithResult),
    .writeEn (arithWe)
  );

  // Next-state and control decode: accept only in IDLE, count down in RUN, commit when the count reaches zero.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    loadOp    = 1'b0;
    commit    = 1'b0;
    writeHi   = 1'b0;
    writeLo   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (isMulOp(bus.op)) begin
            loadOp    = 1'b1;
            cntNext   = MULT_LOAD;
            stateNext = ST_RUN;
          end else if (isDivOp(bus.op)) begin
            loadOp    = 1'b1;
            cntNext   = DIV_LOAD;
            stateNext = ST_RUN;
          end else if (bus.op == OP_MTHI) begin
            writeHi = 1'b1;
          end else if (bus.op == OP_MTLO) begin
            writeLo = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (cnt == '0) begin
          commit    = 1'b1;
          stateNext = ST_IDLE;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // State, counter, operand latches and HI/LO; reset aborts any operation without a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      opLat <= OP_NONE;
      rsLat <= '0;
      rtLat <= '0;
      hiReg <= '0;
      loReg <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (loadOp) begin
        opLat <= bus.op;
        rsLat <= bus.rs_data;
        rtLat <= bus.rt_data;
      end
      if (commit && arithWe) begin
        hiReg <= arithResult[63:32];
        loReg <= arithResult[31:0];
      end
      if (writeHi) hiReg <= bus.rs_data;
      if (writeLo) loReg <= bus.rs_data;
    end
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - scoreboard bench for mdu_sequencer; MDU_MADD_EN selects the accumulate expectations
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mdu_sequencer_if busIf ();

  mdu_sequencer #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expBusy;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int busyRun = 0;

  task automatic checkVal(input int tag, input string what, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL tag=%0d %s actual=%h required=%h", tag, what, act, req);
    end
  endtask

  // Monitor: a falling busy closes a timed result; a zero-latency entry is checked on the next idle sample.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        busyRun = 0;
      end else if (busIf.busy) begin
        busyRun++;
      end else if (busyRun > 0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_busy actual=%0d required=0", busyRun);
        end else begin
          e = sb.pop_front();
          checkVal(e.tag, "hi", busIf.hi, e.expHi);
          checkVal(e.tag, "lo", busIf.lo, e.expLo);
          checkVal(e.tag, "busy_cycles", 32'(busyRun), 32'(e.expBusy));
        end
        busyRun = 0;
      end else if (sb.size() > 0 && sb[0].expBusy == 0) begin
        e = sb.pop_front();
        checkVal(e.tag, "hi", busIf.hi, e.expHi);
        checkVal(e.tag, "lo", busIf.lo, e.expLo);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    busIf.start   = 1'b1;
    busIf.op      = o;
    busIf.rs_data = a;
    busIf.rt_data = b;
    cycle();
    busIf.start   = 1'b0;
  endtask

  task automatic pushExp(input int tag, input logic [31:0] h, input logic [31:0] l, input int n);
    exp_t e;
    e.tag = tag;
    e.expHi = h;
    e.expLo = l;
    e.expBusy = n;
    sb.push_back(e);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 40) begin
      cycle();
      k++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", sb.size());
      sb.delete();
    end
    cycle();
  endtask

  initial begin
    busIf.start   = 1'b0;
    busIf.op      = OP_NONE;
    busIf.rs_data = '0;
    busIf.rt_data = '0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    pushExp(0, 32'h0, 32'h0, 0);
    drain();

    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    pushExp(1, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    drain();

    issue(OP_MULTU, 32'hFFFFFFFE, 32'd3);
    pushExp(2, 32'h00000002, 32'hFFFFFFFA, 5);
    drain();

    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    pushExp(3, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    drain();

    issue(OP_MTHI, 32'h00001234, 32'h0);
    pushExp(4, 32'h00001234, 32'hFFFFFFFD, 0);
    drain();

    issue(OP_DIVU, 32'd7, 32'd0);
    pushExp(5, 32'h00001234, 32'hFFFFFFFD, 10);
    drain();

    issue(OP_MTLO, 32'hCAFEBABE, 32'h0);
    pushExp(6, 32'h00001234, 32'hCAFEBABE, 0);
    drain();

    issue(OP_MULT, 32'h00010000, 32'h00010000);
    pushExp(7, 32'h00000001, 32'h00000000, 5);
    drain();

    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    pushExp(8, 32'h00000000, 32'h80000000, 10);
    drain();

    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    pushExp(9, 32'h00000001, 32'hFFFFFFFD, 10);
    drain();

    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    pushExp(10, 32'hFFFFFFFE, 32'h00000001, 5);
    drain();

    issue(OP_DIV, 32'd100, 32'd7);
    pushExp(11, 32'h00000002, 32'h0000000E, 10);
    for (int i = 0; i < 10; i++) begin
      busIf.rs_data = $urandom;
      busIf.rt_data = $urandom;
      if (i == 2) begin
        busIf.start = 1'b1;
        busIf.op    = OP_MULT;
      end
      cycle();
      busIf.start = 1'b0;
    end
    drain();

    issue(4'hF, 32'h11111111, 32'h22222222);
    pushExp(12, 32'h00000002, 32'h0000000E, 0);
    drain();

`ifdef MDU_MADD_EN
    issue(OP_MTHI, 32'h0, 32'h0);
    pushExp(13, 32'h00000000, 32'h0000000E, 0);
    drain();
    issue(OP_MTLO, 32'hFFFFFFFF, 32'h0);
    pushExp(14, 32'h00000000, 32'hFFFFFFFF, 0);
    drain();
    issue(OP_MADDU, 32'd1, 32'd1);
    pushExp(15, 32'h00000001, 32'h00000000, 5);
    drain();
    issue(OP_MSUB, 32'd1, 32'd1);
    pushExp(16, 32'h00000000, 32'hFFFFFFFF, 5);
    drain();
`else
    issue(OP_MADDU, 32'd1, 32'd1);
    pushExp(15, 32'h00000002, 32'h0000000E, 0);
    drain();
    issue(OP_MSUB, 32'd1, 32'd1);
    pushExp(16, 32'h00000002, 32'h0000000E, 0);
    drain();
`endif

    issue(OP_MULT, 32'd3, 32'd4);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    pushExp(17, 32'h0, 32'h0, 0);
    drain();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
